// File: rtl/param_sdp_mem.sv
// rtl/param_sdp_mem.sv - simple dual-port RAM with power-up clear, read-first, range-checked access
// Define PARAM_SDP_MEM_OUTREG_EN to add a second output register stage (read latency 2).
module param_sdp_mem #(
  parameter int DATA_W = 22,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              init_busy,
  output logic              addr_err
);

  typedef enum logic {S_INIT, S_READY} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH-1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic                w_init_busy;
  logic                w_ready;
  logic                w_last;
  logic                w_wr_in_range;
  logic                w_rd_in_range;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_data;
  logic                w_rd_en;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic                r_addr_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_busy = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_busy = 1'b1;
        w_last      = (r_cnt == LAST_A);
        if (w_last) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign w_ready       = (r_state == S_READY);
  assign w_wr_in_range = ({1'b0, waddr} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, raddr} < DEPTH_L);
  assign w_rd_en       = w_ready & re;

  // The clear sequence owns the write port until READY; user writes go nowhere meanwhile.
  assign w_mem_we   = w_init_busy | (w_ready & we & w_wr_in_range);
  assign w_mem_addr = w_init_busy ? r_cnt : waddr;
  assign w_mem_data = w_init_busy ? '0 : wdata;

  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_rvalid <= w_rd_en;
      if (w_rd_en) begin
        r_rdata <= w_rd_in_range ? r_mem[raddr] : '0;
      end
      if ((w_ready & we & ~w_wr_in_range) | (w_rd_en & ~w_rd_in_range)) begin
        r_addr_err <= 1'b1;
      end
    end
  end

`ifdef PARAM_SDP_MEM_OUTREG_EN
  logic [DATA_W-1:0] r_rdata_q;
  logic              r_rvalid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata_q  <= '0;
      r_rvalid_q <= 1'b0;
    end else begin
      r_rdata_q  <= r_rdata;
      r_rvalid_q <= r_rvalid;
    end
  end

  assign rdata  = r_rdata_q;
  assign rvalid = r_rvalid_q;
`else
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
`endif

  assign init_busy = w_init_busy;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_param_sdp_mem.sv
// tb/tb_param_sdp_mem.sv - directed self-checking bench for param_sdp_mem
// Drives a full-depth instance and a DEPTH=320 instance from shared inputs.
`timescale 1ns/1ps
module tb_param_sdp_mem;

  localparam int DW = 22;
  localparam int AW = 9;
`ifdef PARAM_SDP_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b;
  logic          busy_a, busy_b;
  logic          err_a, err_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_sdp_mem #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
    .init_busy(busy_a), .addr_err(err_a)
  );

  param_sdp_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(320)) dut320 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
    .init_busy(busy_b), .addr_err(err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic release_and_measure(output int na, output int nb);
    int n;
    na = 0;
    nb = 0;
    n  = 0;
    rst_n = 1'b1;
    while ((busy_a || busy_b) && n < 2000) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    waddr = '0; wdata = '0; raddr = '0;
    repeat (3) tick();
    checks++;
    if (rdata_a !== '0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", rdata_a); end
    checks++;
    if (rvalid_a !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid_a); end
    checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      failures++; $display("FAIL reset_busy got=%0b/%0b exp=1/1", busy_a, busy_b);
    end
    checks++;
    if (err_a !== 1'b0 || err_b !== 1'b0) begin
      failures++; $display("FAIL reset_addr_err got=%0b/%0b exp=0/0", err_a, err_b);
    end
  endtask

  task automatic test_init();
    int na, nb, idx, bad;
    release_and_measure(na, nb);
    checks++;
    if (na != 512) begin failures++; $display("FAIL init_len_512 got=%0d exp=512", na); end
    checks++;
    if (nb != 320) begin failures++; $display("FAIL init_len_320 got=%0d exp=320", nb); end
    bad = 0;
    for (int j = 0; j < 512 + LAT - 1; j++) begin
      if (j < 512) begin
        re = 1'b1;
        raddr = AW'(j);
      end else begin
        re = 1'b0;
      end
      tick();
      idx = j - (LAT - 1);
      if (idx >= 0 && idx < 512) begin
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== '0) begin
          failures++;
          $display("FAIL init_clear_read addr=%0d got=%0h/%0b exp=0/1", idx, rdata_a, rvalid_a);
        end
      end
    end
    idle();
    tick();
    checks++;
    if (rvalid_a !== 1'b0) begin failures++; $display("FAIL init_read_end_rvalid got=%0b exp=0", rvalid_a); end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 9'd5; wdata = 22'h2AAAAA;
    tick();
    we = 1'b0; re = 1'b1; raddr = 9'd5;
    tick();
    re = 1'b0;
`ifdef PARAM_SDP_MEM_OUTREG_EN
    checks++;
    if (rvalid_a !== 1'b0) begin failures++; $display("FAIL outreg_early_rvalid got=%0b exp=0", rvalid_a); end
    tick();
`endif
    checks++;
    if (rdata_a !== 22'h2AAAAA || rvalid_a !== 1'b1) begin
      failures++; $display("FAIL wr_rd_5 got=%0h/%0b exp=2aaaaa/1", rdata_a, rvalid_a);
    end
    tick();
    checks++;
    if (rvalid_a !== 1'b0 || rdata_a !== 22'h2AAAAA) begin
      failures++; $display("FAIL rvalid_pulse_hold got=%0h/%0b exp=2aaaaa/0", rdata_a, rvalid_a);
    end
  endtask

  task automatic test_read_first();
    we = 1'b1; waddr = 9'd7; wdata = 22'h000001;
    tick();
    wdata = 22'h000003; re = 1'b1; raddr = 9'd7;
    tick();
    idle();
    repeat (LAT - 1) tick();
    checks++;
    if (rdata_a !== 22'h000001 || rvalid_a !== 1'b1) begin
      failures++; $display("FAIL read_first_old got=%0h/%0b exp=1/1", rdata_a, rvalid_a);
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    repeat (LAT - 1) tick();
    checks++;
    if (rdata_a !== 22'h000003 || rvalid_a !== 1'b1) begin
      failures++; $display("FAIL read_first_new got=%0h/%0b exp=3/1", rdata_a, rvalid_a);
    end
  endtask

  task automatic test_simul();
    we = 1'b1; waddr = 9'd10; wdata = 22'h123456;
    re = 1'b1; raddr = 9'd5;
    tick();
    idle();
    repeat (LAT - 1) tick();
    checks++;
    if (rdata_a !== 22'h2AAAAA || rvalid_a !== 1'b1) begin
      failures++; $display("FAIL simul_read got=%0h/%0b exp=2aaaaa/1", rdata_a, rvalid_a);
    end
    re = 1'b1; raddr = 9'd10;
    tick();
    re = 1'b0;
    repeat (LAT - 1) tick();
    checks++;
    if (rdata_a !== 22'h123456 || rvalid_a !== 1'b1) begin
      failures++; $display("FAIL simul_write got=%0h/%0b exp=123456/1", rdata_a, rvalid_a);
    end
  endtask

  task automatic test_init_ignore();
    int bad, n;
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    we = 1'b1; waddr = 9'd3; wdata = 22'h155555;
    re = 1'b1; raddr = 9'd400;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL init_rvalid_quiet got=%0d exp=0", bad); end
    idle();
    n = 0;
    while (busy_a && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL init_ignore_timeout got=%0b exp=0", busy_a); end
    checks++;
    if (err_b !== 1'b0) begin failures++; $display("FAIL init_ignore_addr_err got=%0b exp=0", err_b); end
    re = 1'b1; raddr = 9'd3;
    tick();
    re = 1'b0;
    repeat (LAT - 1) tick();
    checks++;
    if (rdata_a !== '0 || rvalid_a !== 1'b1) begin
      failures++; $display("FAIL init_ignore_write got=%0h/%0b exp=0/1", rdata_a, rvalid_a);
    end
  endtask

  task automatic test_mid_reset();
    int na, nb;
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_init_busy got=%0b exp=1", busy_a); end
    rst_n = 1'b0;
    tick();
    release_and_measure(na, nb);
    checks++;
    if (na != 512) begin failures++; $display("FAIL mid_reset_len got=%0d exp=512", na); end
    checks++;
    if (err_a !== 1'b0 || err_b !== 1'b0) begin
      failures++; $display("FAIL mid_reset_addr_err got=%0b/%0b exp=0/0", err_a, err_b);
    end
  endtask

  task automatic test_addr_err();
    we = 1'b1; waddr = 9'd400; wdata = 22'h3FFFFF;
    tick();
    we = 1'b0;
    checks++;
    if (err_b !== 1'b1 || err_a !== 1'b0) begin
      failures++; $display("FAIL oor_write_err got=%0b/%0b exp=0/1", err_a, err_b);
    end
    re = 1'b1; raddr = 9'd400;
    tick();
    re = 1'b0;
    repeat (LAT - 1) tick();
    checks++;
    if (rdata_b !== '0 || rvalid_b !== 1'b1) begin
      failures++; $display("FAIL oor_read got=%0h/%0b exp=0/1", rdata_b, rvalid_b);
    end
    checks++;
    if (rdata_a !== 22'h3FFFFF || err_a !== 1'b0) begin
      failures++; $display("FAIL full_depth_400 got=%0h/%0b exp=3fffff/0", rdata_a, err_a);
    end
    re = 1'b1; raddr = 9'd144;
    tick();
    re = 1'b0;
    repeat (LAT - 1) tick();
    checks++;
    if (rdata_b !== '0 || rvalid_b !== 1'b1) begin
      failures++; $display("FAIL no_wrap_144 got=%0h/%0b exp=0/1", rdata_b, rvalid_b);
    end
    we = 1'b1; waddr = 9'd9; wdata = 22'h0ABCDE;
    tick();
    we = 1'b0; re = 1'b1; raddr = 9'd9;
    tick();
    re = 1'b0;
    repeat (LAT + 3) tick();
    checks++;
    if (rdata_b !== 22'h0ABCDE || err_b !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%0h/%0b exp=abcde/1", rdata_b, err_b);
    end
  endtask

  task automatic test_reset_inflight();
    re = 1'b1; raddr = 9'd9;
    tick();
    rst_n = 1'b0;
    re = 1'b0;
    tick();
    checks++;
    if (rvalid_a !== 1'b0 || rdata_a !== '0 || err_b !== 1'b0) begin
      failures++; $display("FAIL reset_clears got=%0h/%0b/%0b exp=0/0/0", rdata_a, rvalid_a, err_b);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (rvalid_a !== 1'b0) begin failures++; $display("FAIL reset_inflight got=%0b exp=0", rvalid_a); end
    tick();
    checks++;
    if (rvalid_a !== 1'b0 || busy_a !== 1'b1) begin
      failures++; $display("FAIL reset_inflight_late got=%0b/%0b exp=0/1", rvalid_a, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_read_first();
    test_simul();
    test_init_ignore();
    test_mid_reset();
    test_addr_err();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_sdp_mem.md
PARAM_SDP_MEM -- requirements
Module: param_sdp_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 22, word width in bits (1..512).
REQ-002 SHALL have parameter ADDR_W, default 9, address width in bits (1..16).
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, number of implemented words (1..2**ADDR_W).
REQ-004 SHALL have port clk  input  1  single clock for all logic; every register updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_W  write address.
REQ-008 SHALL have port wdata  input  DATA_W  write data.
REQ-009 SHALL have port re  input  1  read enable.
REQ-010 SHALL have port raddr  input  ADDR_W  read address.
REQ-011 SHALL have port rdata  output  DATA_W  read data.
REQ-012 SHALL have port rvalid  output  1  single-cycle pulse marking rdata valid.
REQ-013 SHALL have port init_busy  output  1  high while the memory-clear sequence runs.
REQ-014 SHALL have port addr_err  output  1  sticky flag; high once any out-of-range access has been accepted.

Function
REQ-015 SHALL implement a two-state FSM: INIT, READY.
REQ-016 In INIT, the block SHALL write zero to word cnt each cycle.
- cnt runs 0..DEPTH-1.
- After writing DEPTH-1, the FSM moves to READY.
- INIT therefore lasts exactly DEPTH cycles after rst_n rises.
REQ-017 init_busy SHALL be 1 in INIT and 0 in READY.
REQ-018 In INIT, we and re SHALL be ignored, and rvalid SHALL stay 0.
REQ-019 In READY, a write with we=1 and waddr<DEPTH SHALL update mem[waddr] at that clock edge.
REQ-020 In READY, a read with re=1 at edge N SHALL present mem[raddr] on rdata with rvalid=1 after edge N+1 (latency 1).
REQ-021 When re=0, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-022 On a same-cycle write and read to the same address, rdata SHALL return the old contents (read-first).
REQ-023 Back-to-back reads SHALL be accepted every cycle: full throughput, no stall.
REQ-024 A write with waddr>=DEPTH SHALL be dropped and SHALL set addr_err.
REQ-025 A read with raddr>=DEPTH SHALL return all-zero data with rvalid=1 and SHALL set addr_err.
REQ-026 Only the low ADDR_W address bits SHALL be used; no address wrap-around is applied.
REQ-027 Simultaneous valid read and write to different addresses SHALL both complete in the same cycle.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL:
- enter INIT with cnt=0;
- drive rdata=0, rvalid=0, init_busy=1, addr_err=0.
REQ-029 Reset asserted mid-INIT or mid-READY SHALL restart the full DEPTH-cycle clear.
REQ-030 Reset SHALL discard any in-flight read, so no rvalid pulse follows reset.

Configuration
REQ-031 With macro PARAM_SDP_MEM_OUTREG_EN defined, the block SHALL add a second output register stage:
- read latency becomes 2 cycles;
- rdata and rvalid are delayed together;
- the extra stage resets to 0.
REQ-032 With PARAM_SDP_MEM_OUTREG_EN undefined, read latency SHALL be 1 cycle exactly as in REQ-020.

Verification
REQ-033 Release rst_n, then hold we=0 and re=0 -> init_busy=1 for exactly 512 cycles; afterwards, reading addresses 0..511 returns 0x000000 each.
REQ-034 READY; write 0x2AAAAA to address 5, then re=1 with raddr=5 -> after one cycle rdata=0x2AAAAA with rvalid=1 for exactly one cycle.
REQ-035 mem[7]=0x000001; same-cycle write of 0x000003 to address 7 and read of address 7 -> rdata=0x000001; the next read of address 7 returns 0x000003.
REQ-036 DEPTH=320; write address 400, then read address 400 -> write dropped, rdata=0 with rvalid=1, addr_err=1 and it stays 1 until reset.
REQ-037 Assert rst_n=0 at INIT cycle 100, then release -> init_busy stays high for a fresh 512 cycles and addr_err=0.
REQ-038 With PARAM_SDP_MEM_OUTREG_EN defined, read address 5 holding 0x2AAAAA -> rdata=0x2AAAAA and rvalid=1 two cycles after the re edge, with nothing valid after one cycle.
